// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
// Shared types and sizing helpers for the fifo_bank read-side packer.
package fifo_pkg;

   typedef enum logic {FILL = 1'b0, SEND = 1'b1} pack_state_e;

   // Lane counter width: holds 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Idle counter width: holds 0..t, still one bit when the timeout is disabled.
   function automatic int idle_width(input int t);
      return (t <= 0) ? 1 : $clog2(t + 1);
   endfunction

   // Byte-enable mask width is one bit per lane.
   function automatic int be_width(input int pack_ratio);
      return pack_ratio;
   endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
`timescale 1ns/1ps
// fifo_rd_packer: drains the FWFT fifo_bank read port and packs PACK_RATIO
// entries into one wide word on a valid/ready output. Partial words leave on
// flush or idle timeout, tagged with a byte-enable mask and last.
//
// state | meaning
// FILL  | popping entries into lanes, watching for full word / close-out
// SEND  | word presented on out_valid_o, held until out_ready_i
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int TIMEOUT    = 16
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]            fifo_rdata_i,
   output logic                             fifo_ren_o,
   input  logic                             flush_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data_o,
   output logic [be_width(PACK_RATIO)-1:0]  out_be_o,
   output logic                             out_last_o,
   output logic                             busy_o
);

   localparam int CNT_W  = cnt_width(PACK_RATIO);
   localparam int IDLE_W = idle_width(TIMEOUT);
   localparam int OUT_W  = DATA_WIDTH * PACK_RATIO;
   localparam int BE_W   = be_width(PACK_RATIO);

   pack_state_e        r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_flush_pend;
   logic [IDLE_W-1:0]  r_idle;
   logic [OUT_W-1:0]   r_data;
   logic [BE_W-1:0]    r_be;
   logic               r_last;

   logic               w_pop;
   logic [CNT_W:0]     w_cnt_next;
   logic               w_full;
   logic               w_timeout;
   logic               w_close;
   logic [BE_W-1:0]    w_be_part;

   // Pops only in FILL; gated by rst so nothing leaves the FIFO during reset.
   assign w_pop      = !rst && (r_state == FILL) && !fifo_empty_i;
   assign w_cnt_next = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);
   assign w_full     = w_pop && (r_cnt == CNT_W'(PACK_RATIO - 1));
   assign w_timeout  = (TIMEOUT != 0) && (r_idle == IDLE_W'(TIMEOUT));
   assign w_close    = r_flush_pend || flush_i || w_timeout;

   // Partial-word mask: lanes 0..cnt_next-1 valid.
   always_comb begin
      w_be_part = '0;
      for (int k = 0; k < BE_W; k++) begin
         w_be_part[k] = ((CNT_W+1)'(k) < w_cnt_next);
      end
   end

   // Packing FSM: lane capture, full-word and close-out transitions, handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= FILL;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_data       <= '0;
         r_be         <= '0;
         r_last       <= 1'b0;
      end else if (r_state == FILL) begin
         if (w_pop) begin
            r_data[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata_i;
         end
         if (w_full) begin
            // A flush landing on the completing pop is remembered, not merged.
            r_state      <= SEND;
            r_be         <= '1;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            r_flush_pend <= r_flush_pend | flush_i;
         end else if (w_close) begin
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            if (w_cnt_next != '0) begin
               r_state <= SEND;
               r_be    <= w_be_part;
               r_last  <= 1'b1;
            end
         end else begin
            r_cnt <= w_cnt_next[CNT_W-1:0];
         end
      end else begin
         if (flush_i) begin
            r_flush_pend <= 1'b1;
         end
         if (out_ready_i) begin
            r_state <= FILL;
         end
      end
   end

   // Idle counter: FILL cycles holding a partial word without a pop; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle <= '0;
      end else if ((r_state != FILL) || (r_cnt == '0) || w_pop) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_W'(TIMEOUT)) begin
         r_idle <= r_idle + 1'b1;
      end
   end

   assign fifo_ren_o  = w_pop;
   assign out_valid_o = (r_state == SEND);
   assign out_data_o  = r_data;
   assign out_be_o    = r_be;
   assign out_last_o  = r_last;
   assign busy_o      = (r_cnt != '0) || (r_state == SEND);

endmodule

// File: tb/tb_fifo_rd_packer.sv
`timescale 1ns/1ps
// Directed bench for fifo_rd_packer with a small FWFT FIFO model in front.
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PR = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty_i;
   logic [DW-1:0] fifo_rdata_i;
   logic          fifo_ren_o;
   logic          flush_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic [31:0]   out_data_o;
   logic [3:0]    out_be_o;
   logic          out_last_o;
   logic          busy_o;

   logic [7:0]    mem [256];
   logic [7:0]    wr_ptr = 8'd0;
   logic [7:0]    rd_ptr = 8'd0;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rdata_i (fifo_rdata_i),
      .fifo_ren_o   (fifo_ren_o),
      .flush_i      (flush_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_be_o     (out_be_o),
      .out_last_o   (out_last_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // FWFT FIFO model
   assign fifo_empty_i = (wr_ptr == rd_ptr);
   assign fifo_rdata_i = mem[rd_ptr];
   always @(posedge clk) if (fifo_ren_o) rd_ptr <= rd_ptr + 8'd1;

   typedef struct {
      string       name;
      int          n;
      logic [31:0] din;       // lane k = din[k*8 +: 8]
      int          mode;      // 0 full word, 1 idle timeout, 2 flush with last pop
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
      logic        exp_last;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      while (!out_valid_o && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      if (!out_valid_o) check({name, "_valid_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_drained(input string name);
      int c;
      c = 0;
      while (wr_ptr != rd_ptr && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (wr_ptr != rd_ptr) check({name, "_drain_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic quiet(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (out_valid_o) seen = 1'b1;
      end
      check({name, "_no_extra_word"}, 32'(seen), 32'd0);
      check({name, "_idle_busy"}, 32'(busy_o), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      logic [31:0] mask;
      mask = '0;
      for (int k = 0; k < 4; k++) if (v.exp_be[k]) mask[k*8 +: 8] = 8'hFF;
      if (v.mode == 2) begin
         for (int k = 0; k < v.n - 1; k++) push(v.din[k*8 +: 8]);
         wait_drained(v.name);
         push(v.din[(v.n-1)*8 +: 8]);
         flush_i = 1'b1;
         @(negedge clk);
         flush_i = 1'b0;
      end else begin
         for (int k = 0; k < v.n; k++) push(v.din[k*8 +: 8]);
      end
      wait_valid(v.name, cyc);
      if (v.mode == 0) check({v.name, "_latency"}, 32'(cyc), 32'(PR));
      if (v.mode == 1) check({v.name, "_timeout_window"}, 32'(cyc >= 2 + TO && cyc <= 4 + TO), 32'd1);
      check({v.name, "_data"}, out_data_o & mask, v.exp_data);
      check({v.name, "_be"},   32'(out_be_o),   32'(v.exp_be));
      check({v.name, "_last"}, 32'(out_last_o), 32'(v.exp_last));
      @(negedge clk);
      check({v.name, "_valid_drop"}, 32'(out_valid_o), 32'd0);
      quiet(v.name, 3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      vec_t v;

      vecs[0] = '{"full_1234",   4, 32'h04030201, 0, 32'h04030201, 4'b1111, 1'b0};
      vecs[1] = '{"timeout_56",  2, 32'h00000605, 1, 32'h00000605, 4'b0011, 1'b1};
      vecs[2] = '{"flush_789",   3, 32'h00090807, 2, 32'h00090807, 4'b0111, 1'b1};
      vecs[3] = '{"full_mixed",  4, 32'h2C21160B, 0, 32'h2C21160B, 4'b1111, 1'b0};
      vecs[4] = '{"flush_one",   1, 32'h000000AA, 2, 32'h000000AA, 4'b0001, 1'b1};
      vecs[5] = '{"flush_full",  4, 32'h80030201, 2, 32'h80030201, 4'b1111, 1'b0};
      vecs[6] = '{"timeout_3",   3, 32'h00C3B2A1, 1, 32'h00C3B2A1, 4'b0111, 1'b1};

      // reset values
      #2;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_data",  out_data_o,       32'd0);
      check("rst_be",    32'(out_be_o),    32'd0);
      check("rst_last",  32'(out_last_o),  32'd0);
      check("rst_busy",  32'(busy_o),      32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // backpressure: word held stable, FIFO not popped while in SEND
      out_ready_i = 1'b0;
      push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D); push(8'hEE);
      wait_valid("bp", cyc);
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 32'(out_valid_o), 32'd1);
         check("bp_data",  out_data_o,       32'h0D0C0B0A);
         check("bp_be",    32'(out_be_o),    32'hF);
         check("bp_ren",   32'(fifo_ren_o),  32'd0);
         check("bp_depth", 32'(wr_ptr - rd_ptr), 32'd1);
         @(negedge clk);
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      check("bp_valid_drop", 32'(out_valid_o), 32'd0);
      wait_drained("bp_tail");
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("bp_tail_valid", 32'(out_valid_o),    32'd1);
      check("bp_tail_data",  out_data_o & 32'hFF, 32'hEE);
      check("bp_tail_be",    32'(out_be_o),       32'h1);
      check("bp_tail_last",  32'(out_last_o),     32'd1);
      @(negedge clk);

      // flush with nothing buffered: no word
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      quiet("flush_empty", 5);

      // flush during SEND of a full word: no extra empty word afterwards
      out_ready_i = 1'b0;
      push(8'h31); push(8'h32); push(8'h33); push(8'h34);
      wait_valid("flush_send", cyc);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_send_data", out_data_o,       32'h34333231);
      check("flush_send_last", 32'(out_last_o),  32'd0);
      out_ready_i = 1'b1;
      @(negedge clk);
      check("flush_send_drop", 32'(out_valid_o), 32'd0);
      quiet("flush_send", 6);
      v = '{"after_flush", 4, 32'h44434241, 0, 32'h44434241, 4'b1111, 1'b0};
      run_vec(v);

      // reset mid-word discards partial lanes
      push(8'h55); push(8'h66);
      wait_drained("mid_rst");
      check("mid_rst_busy_before", 32'(busy_o), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid_o), 32'd0);
      check("mid_rst_data",  out_data_o,       32'd0);
      check("mid_rst_be",    32'(out_be_o),    32'd0);
      check("mid_rst_last",  32'(out_last_o),  32'd0);
      check("mid_rst_busy",  32'(busy_o),      32'd0);
      check("mid_rst_ren",   32'(fifo_ren_o),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      v = '{"post_rst", 4, 32'h04030201, 0, 32'h04030201, 4'b1111, 1'b0};
      run_vec(v);
      quiet("post_rst_tail", 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
